// File: rtl/coriolis_stream_src.sv
`default_nettype none
// ============================================================================
// Module : coriolis_stream_src
// Desc   : RAM-buffered valid/ready stream source with a 2-entry output buffer.
// Rev    : 1.0 - initial release
// ============================================================================
module coriolis_stream_src #(
    parameter int STREAMW = 32,
    parameter int DEPTH   = 1024,
    parameter int AW      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [STREAMW-1:0] wr_data,
    input  logic               start,
    input  logic [AW:0]        nwords,
    output logic               busy,
    output logic               done,
    output logic               ovalid,
    output logic [STREAMW-1:0] out1,
    input  logic               iready
);

    localparam logic [0:0]  c_ST_IDLE   = 1'b0;
    localparam logic [0:0]  c_ST_STREAM = 1'b1;
    localparam logic [AW:0] c_CNT_ONE   = {{AW{1'b0}}, 1'b1};

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [STREAMW-1:0] r_mem [DEPTH];
    logic [STREAMW-1:0] r_q;
    logic [STREAMW-1:0] r_skid;
    logic               r_q_vld;
    logic               r_skid_vld;
    logic [AW:0]        r_nwords;
    logic [AW:0]        r_rd_cnt;
    logic [AW:0]        r_xfer_cnt;
    logic               r_done;
    logic               w_busy;
    logic               w_rd_en;
    logic               w_xfer;
    logic               w_last_xfer;
    logic               w_start;
    logic               w_zero_start;

    // The skid entry always holds the older word, so it has priority on the output.
    assign ovalid = r_skid_vld | r_q_vld;
    assign out1   = r_skid_vld ? r_skid : r_q;
    assign busy   = w_busy;
    assign done   = r_done;

    assign w_xfer       = ovalid & iready;
    assign w_last_xfer  = (r_state == c_ST_STREAM) && w_xfer
                          && (r_xfer_cnt == (r_nwords - c_CNT_ONE));
    assign w_start      = (r_state == c_ST_IDLE) && start;
    assign w_zero_start = w_start && (nwords == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start && (nwords != '0)) begin
                    w_state_nxt = c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                if (w_last_xfer) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // A read is only issued while the skid entry is free: at worst the word
    // in r_q is pushed into it, so the incoming word always has a home.
    always_comb begin
        w_busy  = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            c_ST_STREAM: begin
                w_busy  = 1'b1;
                w_rd_en = (r_rd_cnt != r_nwords) && !r_skid_vld;
            end
            default: begin
                w_busy  = 1'b0;
                w_rd_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nwords   <= '0;
            r_rd_cnt   <= '0;
            r_xfer_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_xfer || w_zero_start;
            if (w_start) begin
                r_nwords   <= nwords;
                r_rd_cnt   <= '0;
                r_xfer_cnt <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + c_CNT_ONE;
                end
                if (w_xfer) begin
                    r_xfer_cnt <= r_xfer_cnt + c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !w_busy) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // r_q only changes on a read, so it naturally keeps the last delivered word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= '0;
            r_q_vld    <= 1'b0;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
        end else begin
            if (r_skid_vld) begin
                if (iready) begin
                    r_skid_vld <= 1'b0;
                end
            end else begin
                if (w_rd_en && r_q_vld && !iready) begin
                    r_skid     <= r_q;
                    r_skid_vld <= 1'b1;
                end
                r_q_vld <= w_rd_en | (r_q_vld & ~iready);
            end
            if (w_rd_en) begin
                r_q <= r_mem[r_rd_cnt[AW-1:0]];
            end
        end
    end

endmodule
`default_nettype wire
